// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed scan controller for a 4-digit
// seven-segment display feeding a 2-to-4 digit decoder.
// Each digit slot is REFRESH_DIV clocks: BLANK_CYCLES with En low (anti-ghosting),
// then the rest with En high. New results are buffered in a shadow register
// and only applied at the frame wrap (digit 3 -> digit 0) to avoid tearing.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module digit_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [1:0]  s,
    output logic        En,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      idx_reg, idx_next;
    // run_reg is low only for the reset state; the first clock after reset
    // release becomes cycle 0 of the digit-0 slot.
    logic            run_reg;
    logic [19:0]     active_reg, active_next;   // {dp[3:0], digits[15:0]}
    logic [19:0]     shadow_reg;
    logic            pending_reg, pending_next;
    logic            wrap;
    logic [3:0]      nib_next;
    logic [3:0]      dp_vec_next;
    logic [3:0]      lz_mask;

    // Hex to gfedcba segment pattern, active-high.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h3F;
            4'h1: seg_of = 7'h06;
            4'h2: seg_of = 7'h5B;
            4'h3: seg_of = 7'h4F;
            4'h4: seg_of = 7'h66;
            4'h5: seg_of = 7'h6D;
            4'h6: seg_of = 7'h7D;
            4'h7: seg_of = 7'h07;
            4'h8: seg_of = 7'h7F;
            4'h9: seg_of = 7'h6F;
            4'hA: seg_of = 7'h77;
            4'hB: seg_of = 7'h7C;
            4'hC: seg_of = 7'h39;
            4'hD: seg_of = 7'h5E;
            4'hE: seg_of = 7'h79;
            default: seg_of = 7'h71;
        endcase
    endfunction

    // Slot sequencing: next counter, digit index and phase; flags the frame wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        wrap       = 1'b0;
        if (!run_reg) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = 2'd0;
        end else if (state_reg == BLANK) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == BLANK_LAST) begin
                state_next = SHOW;
            end
        end else if (cnt_reg == SLOT_LAST) begin
            cnt_next   = '0;
            state_next = BLANK;
            idx_next   = idx_reg + 2'd1;
            wrap       = (idx_reg == 2'd3);
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Tear-free update: shadow is promoted only at the wrap; a load landing on
    // the wrap itself bypasses the shadow and goes straight to the display.
    always_comb begin
        active_next  = active_reg;
        pending_next = pending_reg;
        if (wrap) begin
            pending_next = 1'b0;
            if (load) begin
                active_next = {dp_in, digits_in};
            end else if (pending_reg) begin
                active_next = shadow_reg;
            end
        end else if (load) begin
            pending_next = 1'b1;
        end
        nib_next    = active_next[{idx_next, 2'b00} +: 4];
        dp_vec_next = active_next[19:16];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every higher digit are zero and its
    // decimal point is off; digit 0 always stays lit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            if (gi == 0) begin : g_d0
                assign lz_mask[gi] = 1'b0;
            end else begin : g_dn
                assign lz_mask[gi] = ~(|active_next[15:4*gi]) & ~active_next[16+gi];
            end
        end
    endgenerate
`else
    assign lz_mask = 4'b0000;
`endif

    // State, data registers and registered outputs; outputs track the next state
    // so they line up with the cycle the state registers describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= BLANK;
            cnt_reg     <= '0;
            idx_reg     <= 2'd0;
            run_reg     <= 1'b0;
            active_reg  <= '0;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
            s           <= 2'd0;
            En          <= 1'b0;
            seg         <= 7'h00;
            dp          <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            run_reg     <= 1'b1;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            if (load) begin
                shadow_reg <= {dp_in, digits_in};
            end
            s          <= idx_next;
            En         <= (state_next == SHOW) && !lz_mask[idx_next];
            seg        <= seg_of(nib_next);
            dp         <= dp_vec_next[idx_next];
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed bench for digit_scan_ctrl with REFRESH_DIV=8,
// BLANK_CYCLES=2. Cycle c counts clocks from reset release; a slot is 8 cycles,
// a frame 32. Expected per-digit segment/dp/enable values are hand-entered.
module tb_digit_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic [1:0]  s;
    logic        en;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int c = 0;

    logic [6:0] cur_seg [4];
    logic [6:0] nxt_seg [4];
    logic       cur_dp  [4];
    logic       nxt_dp  [4];
    logic       cur_en  [4];
    logic       nxt_en  [4];

    digit_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .s          (s),
        .En         (en),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s c=%0d got=%h exp=%h", tag, c, got, exp);
        end
    endtask

    task automatic set_all(input logic [6:0] sg, input logic d, input logic e);
        for (int i = 0; i < 4; i++) begin
            cur_seg[i] = sg; nxt_seg[i] = sg;
            cur_dp[i]  = d;  nxt_dp[i]  = d;
            cur_en[i]  = e;  nxt_en[i]  = e;
        end
    endtask

    task automatic reset_tick();
        @(posedge clk); #1;
        $display("c=rst s=%0d En=%0d seg=%h dp=%0d fd=%0d", s, en, seg, dp, frame_done);
        check("rst_s",   16'(s),          16'd0);
        check("rst_en",  16'(en),         16'd0);
        check("rst_seg", 16'(seg),        16'h00);
        check("rst_dp",  16'(dp),         16'd0);
        check("rst_fd",  16'(frame_done), 16'd0);
    endtask

    task automatic tick_check();
        int d;
        int pos;
        @(posedge clk); #1;
        load = 1'b0;
        if (c % 32 == 0 && c > 0) begin
            for (int i = 0; i < 4; i++) begin
                cur_seg[i] = nxt_seg[i];
                cur_dp[i]  = nxt_dp[i];
                cur_en[i]  = nxt_en[i];
            end
        end
        d   = (c / 8) % 4;
        pos = c % 8;
        $display("c=%0d s=%0d En=%0d seg=%h dp=%0d fd=%0d", c, s, en, seg, dp, frame_done);
        check("s",          16'(s),          16'(d));
        check("en",         16'(en),         16'(pos >= 2 && cur_en[d]));
        check("seg",        16'(seg),        16'(cur_seg[d]));
        check("dp",         16'(dp),         16'(cur_dp[d]));
        check("frame_done", 16'(frame_done), 16'(c % 32 == 0 && c > 0));
        c++;
    endtask

    // Check every cycle up to and including cycle n.
    task automatic run_to(input int n);
        while (c <= n) tick_check();
    endtask

    initial begin
        set_all(7'h3F, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (3) reset_tick();
        rst_n = 1'b1;
        c = 0;

        // Frame 0: all zeros; load 1234 mid-slot of digit 1 (applies next frame).
        run_to(10);
        digits_in = 16'h1234; dp_in = 4'b0010; load = 1'b1;
        nxt_seg[0] = 7'h66; nxt_seg[1] = 7'h4F; nxt_seg[2] = 7'h5B; nxt_seg[3] = 7'h06;
        nxt_dp[0] = 1'b0; nxt_dp[1] = 1'b1; nxt_dp[2] = 1'b0; nxt_dp[3] = 1'b0;

        // Frame 1: two loads, the last one wins.
        run_to(40);
        digits_in = 16'hAAAA; dp_in = 4'b1111; load = 1'b1;
        run_to(50);
        digits_in = 16'h00F0; dp_in = 4'b0000; load = 1'b1;
        for (int i = 0; i < 4; i++) begin nxt_seg[i] = 7'h3F; nxt_dp[i] = 1'b0; end
        nxt_seg[1] = 7'h71;

        // Frame 2: load on the last cycle of the frame bypasses into frame 3.
        run_to(95);
        digits_in = 16'h8888; dp_in = 4'b0000; load = 1'b1;
        for (int i = 0; i < 4; i++) nxt_seg[i] = 7'h7F;

        // Frame 3: load FFFF for frame 4.
        run_to(100);
        digits_in = 16'hFFFF; dp_in = 4'b0000; load = 1'b1;
        for (int i = 0; i < 4; i++) nxt_seg[i] = 7'h71;

        // Frame 4: reset during SHOW of digit 2 (c=148 is slot 18, position 4).
        run_to(148);
        rst_n = 1'b0;
        reset_tick();
        rst_n = 1'b1;
        c = 0;
        set_all(7'h3F, 1'b0, 1'b1);

        // After reset: active cleared, then leading-zero case 0050.
        run_to(40);
        digits_in = 16'h0050; dp_in = 4'b0000; load = 1'b1;
        nxt_seg[1] = 7'h6D;
`ifdef LEADING_ZERO_BLANK_EN
        nxt_en[2] = 1'b0;
        nxt_en[3] = 1'b0;
`endif
        run_to(95);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
